// File: rtl/brent_kung_32.sv
// 32-bit adder with carry-in/out built on an explicit Brent-Kung prefix network.
// Five up-sweep and four down-sweep levels feed a single registered output stage.
module brent_kung_32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] out,
    output logic        cout
);

    localparam int W = 32;

    // Group-generate of a span: the high half generates, or propagates the low half's generate.
    function automatic logic carry_op(input logic g_hi, input logic p_hi, input logic g_lo);
        carry_op = g_hi | (p_hi & g_lo);
    endfunction

    // Full prefix operator on {generate, propagate} pairs.
    function automatic logic [1:0] prefix_op(input logic [1:0] hi, input logic [1:0] lo);
        prefix_op = {carry_op(hi[1], hi[0], lo[1]), hi[0] & lo[0]};
    endfunction

    logic [W-1:0] gen_s;
    logic [W-1:0] prop_s;
    logic [W-1:0] g0_s,  p0_s;
    logic [W-1:0] up1_g_s, up1_p_s;
    logic [W-1:0] up2_g_s, up2_p_s;
    logic [W-1:0] up3_g_s, up3_p_s;
    logic [W-1:0] up4_g_s, up4_p_s;
    logic [W-1:0] up5_g_s, up5_p_s;
    logic [W-1:0] dn4_g_s, dn4_p_s;
    logic [W-1:0] dn3_g_s, dn3_p_s;
    logic [W-1:0] dn2_g_s, dn2_p_s;
    logic [W-1:0] carry_s;
    logic [W-1:0] sum_s;

    assign gen_s  = a & b;
    assign prop_s = a ^ b;
    // cin enters as the generate of bit 0 so the network yields true carries directly.
    assign g0_s   = {gen_s[W-1:1], gen_s[0] | (prop_s[0] & cin)};
    assign p0_s   = prop_s;

    for (genvar i = 0; i < W; i++) begin : g_up1
        if (((i + 1) % 2) == 0) begin : g_op
            assign {up1_g_s[i], up1_p_s[i]} =
                prefix_op({g0_s[i], p0_s[i]}, {g0_s[i-1], p0_s[i-1]});
        end else begin : g_pass
            assign up1_g_s[i] = g0_s[i];
            assign up1_p_s[i] = p0_s[i];
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_up2
        if (((i + 1) % 4) == 0) begin : g_op
            assign {up2_g_s[i], up2_p_s[i]} =
                prefix_op({up1_g_s[i], up1_p_s[i]}, {up1_g_s[i-2], up1_p_s[i-2]});
        end else begin : g_pass
            assign up2_g_s[i] = up1_g_s[i];
            assign up2_p_s[i] = up1_p_s[i];
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_up3
        if (((i + 1) % 8) == 0) begin : g_op
            assign {up3_g_s[i], up3_p_s[i]} =
                prefix_op({up2_g_s[i], up2_p_s[i]}, {up2_g_s[i-4], up2_p_s[i-4]});
        end else begin : g_pass
            assign up3_g_s[i] = up2_g_s[i];
            assign up3_p_s[i] = up2_p_s[i];
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_up4
        if (((i + 1) % 16) == 0) begin : g_op
            assign {up4_g_s[i], up4_p_s[i]} =
                prefix_op({up3_g_s[i], up3_p_s[i]}, {up3_g_s[i-8], up3_p_s[i-8]});
        end else begin : g_pass
            assign up4_g_s[i] = up3_g_s[i];
            assign up4_p_s[i] = up3_p_s[i];
        end
    end

    // Top of the tree: bit 31 now holds the carry out of the whole word.
    for (genvar i = 0; i < W; i++) begin : g_up5
        if (((i + 1) % 32) == 0) begin : g_op
            assign {up5_g_s[i], up5_p_s[i]} =
                prefix_op({up4_g_s[i], up4_p_s[i]}, {up4_g_s[i-16], up4_p_s[i-16]});
        end else begin : g_pass
            assign up5_g_s[i] = up4_g_s[i];
            assign up5_p_s[i] = up4_p_s[i];
        end
    end

    // Down-sweep fills the gaps: at level k the nodes j*2^k + 2^(k-1) - 1 (j >= 1).
    for (genvar i = 0; i < W; i++) begin : g_dn4
        if ((i >= 23) && (((i - 7) % 16) == 0)) begin : g_op
            assign {dn4_g_s[i], dn4_p_s[i]} =
                prefix_op({up5_g_s[i], up5_p_s[i]}, {up5_g_s[i-8], up5_p_s[i-8]});
        end else begin : g_pass
            assign dn4_g_s[i] = up5_g_s[i];
            assign dn4_p_s[i] = up5_p_s[i];
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_dn3
        if ((i >= 11) && (((i - 3) % 8) == 0)) begin : g_op
            assign {dn3_g_s[i], dn3_p_s[i]} =
                prefix_op({dn4_g_s[i], dn4_p_s[i]}, {dn4_g_s[i-4], dn4_p_s[i-4]});
        end else begin : g_pass
            assign dn3_g_s[i] = dn4_g_s[i];
            assign dn3_p_s[i] = dn4_p_s[i];
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_dn2
        if ((i >= 5) && (((i - 1) % 4) == 0)) begin : g_op
            assign {dn2_g_s[i], dn2_p_s[i]} =
                prefix_op({dn3_g_s[i], dn3_p_s[i]}, {dn3_g_s[i-2], dn3_p_s[i-2]});
        end else begin : g_pass
            assign dn2_g_s[i] = dn3_g_s[i];
            assign dn2_p_s[i] = dn3_p_s[i];
        end
    end

    // Last level only needs generates: every bit's group-generate is its carry out.
    for (genvar i = 0; i < W; i++) begin : g_dn1
        if ((i >= 2) && ((i % 2) == 0)) begin : g_op
            assign carry_s[i] = carry_op(dn2_g_s[i], dn2_p_s[i], dn2_g_s[i-1]);
        end else begin : g_pass
            assign carry_s[i] = dn2_g_s[i];
        end
    end

    assign sum_s = prop_s ^ {carry_s[W-2:0], cin};

    // Output register: captures the sum every cycle, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out  <= 32'd0;
            cout <= 1'b0;
        end else begin
            out  <= sum_s;
            cout <= carry_s[W-1];
        end
    end

endmodule

// File: tb/tb_brent_kung_32.sv
// Scoreboard bench for brent_kung_32: the driver queues expected sums, a monitor
// pops one per clock and compares against the registered outputs.
module tb_brent_kung_32;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] out;
    logic        cout;

    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;
    int          checks;
    int          errors;

    brent_kung_32 dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .out  (out),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one result per cycle, sampled just after the capturing edge.
    always @(posedge clk) begin
        #1;
        if (!rst && (exp_q.size() > 0)) begin
            mon_exp = exp_q.pop_front();
            checks++;
            if ({cout, out} !== mon_exp) begin
                errors++;
                $display("FAIL sum: got cout=%0b out=%h, expected cout=%0b out=%h",
                         cout, out, mon_exp[32], mon_exp[31:0]);
            end
        end
    end

    task automatic drive(input logic [31:0] av, input logic [31:0] bv,
                         input logic cv, input logic [32:0] ev);
        @(negedge clk);
        a   = av;
        b   = bv;
        cin = cv;
        exp_q.push_back(ev);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ((out !== 32'd0) || (cout !== 1'b0)) begin
            errors++;
            $display("FAIL %s: got cout=%0b out=%h, expected cout=0 out=00000000",
                     name, cout, out);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a   = 32'd0;
        b   = 32'd0;
        cin = 1'b0;

        #2;
        check_zero("reset_before_edge");
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_hold");
        @(negedge clk);
        rst = 1'b0;

        drive(32'd1024,       32'd1023,       1'b0, 33'd2047);
        drive(32'hFFFF_FFFF,  32'd1,          1'b0, 33'h1_0000_0000);
        drive(32'hFFFF_FFFF,  32'd0,          1'b1, 33'h1_0000_0000);
        drive(32'hAAAA_AAAA,  32'h5555_5555,  1'b0, 33'h0_FFFF_FFFF);
        drive(32'hAAAA_AAAA,  32'h5555_5555,  1'b1, 33'h1_0000_0000);
        drive(32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 33'h1_FFFF_FFFF);
        drive(32'd0,          32'd0,          1'b0, 33'd0);
        drive(32'd0,          32'd0,          1'b1, 33'd1);
        drive(32'h8000_0000,  32'h8000_0000,  1'b0, 33'h1_0000_0000);
        drive(32'h1234_5678,  32'h1111_1111,  1'b0, 33'h0_2345_6789);
        drive(32'h0000_FFFF,  32'h0000_0001,  1'b0, 33'h0_0001_0000);
        drive(32'h7FFF_FFFF,  32'h0000_0000,  1'b1, 33'h0_8000_0000);
        drive(32'h0F0F_0F0F,  32'hF0F0_F0F0,  1'b1, 33'h1_0000_0000);

        // Sampled sweep of the 15-bit operand range.
        for (int ia = 0; ia < 8; ia++) begin
            for (int ib = 0; ib < 8; ib++) begin
                ra = 32'(ia * 4679);
                rb = 32'(ib * 4679);
                drive(ra, rb, 1'b0, {1'b0, ra} + {1'b0, rb});
            end
        end

        for (int n = 0; n < 2000; n++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            drive(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {32'd0, rc});
        end

        // Asynchronous reset between edges, then recovery with the held operands.
        @(negedge clk);
        a   = 32'd5;
        b   = 32'd7;
        cin = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        check_zero("async_reset_hold");
        rst = 1'b0;
        exp_q.push_back(33'd12);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
